mux_rr_arbiter: RTL and testbench



---
 rtl/mux_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 single-bit serial path,
// with valid/ready beat handshake and a hold watchdog on the owner.
module mux_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       out_ready,
    output logic       out,
    output logic       out_valid,
    output logic [3:0] grant,
    output logic       address0,
    output logic       address1,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]    in_vec;
    logic               xfer;
    logic               rel;
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   idx;

    assign in_vec = {in3, in2, in1, in0};

    // Path outputs are decoded from the registered owner; zero when idle.
    always_comb begin
        out_valid = 1'b0;
        out       = 1'b0;
        if (state_q == S_GRANT) begin
            out_valid = req[addr_q];
            out       = in_vec[addr_q];
        end
    end

    assign xfer     = out_valid && out_ready;
    assign busy     = (state_q == S_GRANT);
    assign grant    = grant_q;
    assign address0 = addr_q[0];
    assign address1 = addr_q[1];

    // Next-state: circular scan from the pointer, beat/abort/watchdog release.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        rel     = 1'b0;
        found   = 1'b0;
        pick    = ptr_q;
        idx     = ptr_q;

        for (int k = 0; k < int'(NREQ); k++) begin
            idx = ptr_q + IDX_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    grant_d = NREQ'(1) << pick;
                    addr_d  = pick;
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (!req[addr_q]) begin
                    rel = 1'b1;
                end else if (xfer) begin
                    cnt_d = '0;
                    if (last[addr_q]) begin
                        rel = 1'b1;
                    end
                end else if (cnt_q + CNT_W'(1) == CNT_W'(HOLD_MAX)) begin
                    timeout = 1'b1;
                    rel     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        if (rel) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = addr_q + IDX_W'(1);
            cnt_d   = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: arbitration order, beats, watchdog, abort, reset.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] last;
    logic       in0, in1, in2, in3;
    logic       out_ready;
    logic       out;
    logic       out_valid;
    logic [3:0] grant;
    logic       address0;
    logic       address1;
    logic       busy;
    logic       timeout;

    int vec_cnt;
    int err_cnt;

    mux_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .grant     (grant),
        .address0  (address0),
        .address1  (address1),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit reached, sim did not finish");
        $fatal(1, "time limit");
    end

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b0000; last = 4'b0000;
        {in3, in2, in1, in0} = 4'b0000; out_ready = 1'b0;
        tick(); tick();
        vec_cnt++;
        if ({grant, address1, address0, busy, out_valid, out, timeout} !== 10'b0) begin
            err_cnt++;
            $display("FAIL reset_state got grant=%b addr=%b%b busy=%b ov=%b out=%b to=%b exp all 0",
                     grant, address1, address0, busy, out_valid, out, timeout);
        end
        reset = 1'b0;
        tick();
        vec_cnt++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_idle got grant=%b busy=%b exp 0000/0", grant, busy);
        end
    endtask

    // r0 sends 3 beats (1,0,1), then r2 wins next because the pointer moved past r0.
    task automatic test_basic_message();
        logic [2:0] bits;
        bits = 3'b101;
        req = 4'b0101; last = 4'b0000; out_ready = 1'b1; in0 = 1'b1;
        tick();
        vec_cnt++;
        if (grant !== 4'b0001 || {address1, address0} !== 2'b00 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_first_grant got grant=%b addr=%b%b busy=%b exp 0001/00/1",
                     grant, address1, address0, busy);
        end
        for (int b = 0; b < 3; b++) begin
            in0 = bits[2-b];
            last[0] = (b == 2);
            #1;
            vec_cnt++;
            if (out_valid !== 1'b1 || out !== bits[2-b] || grant !== 4'b0001) begin
                err_cnt++;
                $display("FAIL basic_beat%0d got ov=%b out=%b grant=%b exp 1/%b/0001",
                         b, out_valid, out, grant, bits[2-b]);
            end
            tick();
        end
        last = 4'b0000;
        vec_cnt++;
        if (grant !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0 || out !== 1'b0 ||
            {address1, address0} !== 2'b00) begin
            err_cnt++;
            $display("FAIL basic_bubble got grant=%b busy=%b ov=%b out=%b addr=%b%b exp 0000/0/0/0/00",
                     grant, busy, out_valid, out, address1, address0);
        end
        tick();
        vec_cnt++;
        if (grant !== 4'b0100 || {address1, address0} !== 2'b10) begin
            err_cnt++;
            $display("FAIL basic_second_grant got grant=%b addr=%b%b exp 0100/10",
                     grant, address1, address0);
        end
        last[2] = 1'b1;
        tick();
        last = 4'b0000; req = 4'b0000;
        tick();
    endtask

    // All four requesting with 1-beat messages: strict rotation with wrap 3->0.
    task automatic test_rr_wrap();
        logic [3:0] exp_g [5];
        logic [1:0] exp_a [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset = 1'b1; tick(); reset = 1'b0;
        req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vec_cnt++;
            if (grant !== exp_g[i] || {address1, address0} !== exp_a[i]) begin
                err_cnt++;
                $display("FAIL rr_grant%0d got grant=%b addr=%b%b exp %b/%b",
                         i, grant, address1, address0, exp_g[i], exp_a[i]);
            end
            tick();
            vec_cnt++;
            if (grant !== 4'b0000 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL rr_bubble%0d got grant=%b busy=%b exp 0000/0", i, grant, busy);
            end
        end
        req = 4'b0000; last = 4'b0000;
        tick();
    endtask

    // r2 stalled by out_ready=0: timeout on 8th GRANT cycle, then r3 has priority.
    task automatic test_timeout();
        req = 4'b0100; out_ready = 1'b0; last = 4'b0000;
        tick();
        for (int c = 1; c <= 8; c++) begin
            vec_cnt++;
            if (timeout !== (c == 8) || grant !== 4'b0100) begin
                err_cnt++;
                $display("FAIL timeout_cycle%0d got to=%b grant=%b exp %b/0100",
                         c, timeout, grant, (c == 8));
            end
            if (c < 8) tick();
        end
        req = 4'b1101;
        tick();
        vec_cnt++;
        if (grant !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_release got grant=%b to=%b busy=%b exp 0000/0/0",
                     grant, timeout, busy);
        end
        tick();
        vec_cnt++;
        if (grant !== 4'b1000 || {address1, address0} !== 2'b11) begin
            err_cnt++;
            $display("FAIL timeout_next_ptr got grant=%b addr=%b%b exp 1000/11",
                     grant, address1, address0);
        end
        out_ready = 1'b1; last = 4'b1000;
        tick();
        req = 4'b0000; last = 4'b0000;
        tick();
    endtask

    // r1: transfer on the 8th cycle wins over timeout and clears the counter.
    task automatic test_no_timeout();
        req = 4'b0010; out_ready = 1'b0; last = 4'b0000; in1 = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            out_ready = (c == 8);
            #1;
            vec_cnt++;
            if (timeout !== 1'b0 || grant !== 4'b0010) begin
                err_cnt++;
                $display("FAIL notimeout_cycle%0d got to=%b grant=%b exp 0/0010", c, timeout, grant);
            end
            tick();
        end
        out_ready = 1'b0;
        vec_cnt++;
        if (grant !== 4'b0010 || out_valid !== 1'b1 || out !== 1'b1) begin
            err_cnt++;
            $display("FAIL notimeout_still_owner got grant=%b ov=%b out=%b exp 0010/1/1",
                     grant, out_valid, out);
        end
        for (int c = 1; c <= 8; c++) begin
            vec_cnt++;
            if (timeout !== (c == 8)) begin
                err_cnt++;
                $display("FAIL notimeout_cleared_cycle%0d got to=%b exp %b", c, timeout, (c == 8));
            end
            tick();
        end
        req = 4'b0000; in1 = 1'b0;
        tick();
    endtask

    // r3 drops req mid-message: release, pointer wraps to 0.
    task automatic test_abort();
        req = 4'b1000; out_ready = 1'b1; last = 4'b0000;
        tick();
        tick();
        req = 4'b0001;
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || grant !== 4'b1000) begin
            err_cnt++;
            $display("FAIL abort_no_valid got ov=%b grant=%b exp 0/1000", out_valid, grant);
        end
        tick();
        vec_cnt++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_release got grant=%b busy=%b exp 0000/0", grant, busy);
        end
        req = 4'b1011;
        tick();
        vec_cnt++;
        if (grant !== 4'b0001) begin
            err_cnt++;
            $display("FAIL abort_next_ptr got grant=%b exp 0001", grant);
        end
        last = 4'b0001;
        tick();
        req = 4'b0000; last = 4'b0000;
        tick();
    endtask

    // Reset during r1's 2nd beat aborts and returns pointer to 0.
    task automatic test_reset_mid();
        req = 4'b0010; out_ready = 1'b1; last = 4'b0000;
        tick();
        vec_cnt++;
        if (grant !== 4'b0010) begin
            err_cnt++;
            $display("FAIL rstmid_grant got grant=%b exp 0010", grant);
        end
        tick();
        reset = 1'b1; last = 4'b0010;
        tick();
        reset = 1'b0; last = 4'b0000;
        vec_cnt++;
        if (grant !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0 ||
            {address1, address0} !== 2'b00) begin
            err_cnt++;
            $display("FAIL rstmid_state got grant=%b ov=%b busy=%b addr=%b%b exp 0000/0/0/00",
                     grant, out_valid, busy, address1, address0);
        end
        req = 4'b1111;
        tick();
        vec_cnt++;
        if (grant !== 4'b0001) begin
            err_cnt++;
            $display("FAIL rstmid_ptr got grant=%b exp 0001", grant);
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_basic_message();
        test_rr_wrap();
        test_timeout();
        test_no_timeout();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
